// File: rtl/cv32e40px_div_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40px_div_arbiter
//
// Shares one serial divider (cv32e40px_alu_div) between two requesters. Port 0
// is the core ALU path and port 1 is the auxiliary/accelerator path. The block
// grants the divider round-robin and registers the operands after normalising
// the divisor. It then runs the divider handshake and holds the result until
// the owning requester takes it. Each port can flush its own operation.
//
// Ports (N = 0, 1):
//   Clk_CI, Rst_RBI          clock, asynchronous active-low reset
//   ReqN_OpA_DI/OpB_DI       dividend / divisor
//   ReqN_OpCode_SI           0 udiv, 1 div, 2 urem, 3 rem
//   ReqN_Vld_SI/Rdy_SO       request handshake (Rdy combinational, IDLE only)
//   ReqN_Flush_SI            kill this port's pending or in-flight operation
//   ReqN_ResVld_SO/ResRdy_SI result handshake
//   ReqN_Res_DO              result (both ports share one register)
//   Div*                     divider operand/handshake interface
//   Busy_SO                  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cv32e40px_div_arbiter #(
  parameter int WIDTH     = 32,
  parameter int LOG_WIDTH = 6
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,

  input  logic [WIDTH-1:0]     Req0_OpA_DI,
  input  logic [WIDTH-1:0]     Req0_OpB_DI,
  input  logic [1:0]           Req0_OpCode_SI,
  input  logic                 Req0_Vld_SI,
  output logic                 Req0_Rdy_SO,
  input  logic                 Req0_Flush_SI,
  output logic                 Req0_ResVld_SO,
  input  logic                 Req0_ResRdy_SI,
  output logic [WIDTH-1:0]     Req0_Res_DO,

  input  logic [WIDTH-1:0]     Req1_OpA_DI,
  input  logic [WIDTH-1:0]     Req1_OpB_DI,
  input  logic [1:0]           Req1_OpCode_SI,
  input  logic                 Req1_Vld_SI,
  output logic                 Req1_Rdy_SO,
  input  logic                 Req1_Flush_SI,
  output logic                 Req1_ResVld_SO,
  input  logic                 Req1_ResRdy_SI,
  output logic [WIDTH-1:0]     Req1_Res_DO,

  output logic [WIDTH-1:0]     DivOpA_DO,
  output logic [WIDTH-1:0]     DivOpB_DO,
  output logic [LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                 DivOpBIsZero_SO,
  output logic                 DivOpBSign_SO,
  output logic [1:0]           DivOpCode_SO,
  output logic                 DivInVld_SO,
  output logic                 DivOutRdy_SO,
  input  logic                 DivOutVld_SI,
  input  logic [WIDTH-1:0]     DivRes_DI,

  output logic                 Busy_SO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Divisor normalisation shift. Unsigned: leading-zero count (32 for zero).
  // Signed: redundant sign bits, i.e. leading bits equal to the MSB minus one.
  // XOR with the sign turns that into a leading-zero count whose MSB is always
  // zero, so the count is at least 1 and the decrement cannot wrap.
  function automatic logic [LOG_WIDTH-1:0] normShift(input logic [WIDTH-1:0] b,
                                                     input logic             isSigned);
    logic [WIDTH-1:0]     diff;
    logic [LOG_WIDTH-1:0] lz;
    diff = isSigned ? (b ^ {WIDTH{b[WIDTH-1]}}) : b;
    lz   = LOG_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (diff[i]) lz = LOG_WIDTH'(WIDTH - 1 - i);
    end
    if (isSigned) lz = lz - LOG_WIDTH'(1);
    return lz;
  endfunction

  logic [1:0]           stateQ;
  logic                 ownerQ;
  logic                 lastGntQ;
  logic                 dropQ;
  logic [WIDTH-1:0]     opAQ;
  logic [WIDTH-1:0]     opBQ;
  logic [LOG_WIDTH-1:0] opBShiftQ;
  logic                 opBIsZeroQ;
  logic                 opBSignQ;
  logic [1:0]           opCodeQ;
  logic [WIDTH-1:0]     resQ;

  logic                 idle;
  logic                 elig0;
  logic                 elig1;
  logic                 gnt1;
  logic                 accept;
  logic [WIDTH-1:0]     selA;
  logic [WIDTH-1:0]     selB;
  logic [1:0]           selOp;
  logic [LOG_WIDTH-1:0] selShift;
  logic                 ownerFlush;
  logic                 ownerResRdy;

  assign idle  = (stateQ == IDLE);
  assign elig0 = Req0_Vld_SI & ~Req0_Flush_SI;
  assign elig1 = Req1_Vld_SI & ~Req1_Flush_SI;

  // Port 1 wins when it is the only eligible port, or when both are eligible
  // and port 0 held the last grant.
  assign gnt1   = elig1 & (~elig0 | ~lastGntQ);
  assign accept = idle & (elig0 | elig1);

  assign Req0_Rdy_SO = idle & elig0 & ~gnt1;
  assign Req1_Rdy_SO = idle & gnt1;

  assign selA     = gnt1 ? Req1_OpA_DI    : Req0_OpA_DI;
  assign selB     = gnt1 ? Req1_OpB_DI    : Req0_OpB_DI;
  assign selOp    = gnt1 ? Req1_OpCode_SI : Req0_OpCode_SI;
  assign selShift = normShift(selB, selOp[0]);

  assign ownerFlush  = ownerQ ? Req1_Flush_SI  : Req0_Flush_SI;
  assign ownerResRdy = ownerQ ? Req1_ResRdy_SI : Req0_ResRdy_SI;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      stateQ     <= IDLE;
      ownerQ     <= 1'b0;
      lastGntQ   <= 1'b1;
      dropQ      <= 1'b0;
      opAQ       <= '0;
      opBQ       <= '0;
      opBShiftQ  <= '0;
      opBIsZeroQ <= 1'b0;
      opBSignQ   <= 1'b0;
      opCodeQ    <= 2'b00;
      resQ       <= '0;
    end else begin
      case (stateQ)
        // Accept stage: capture the granted request with its pre-processed divisor.
        IDLE: begin
          if (accept) begin
            opAQ       <= selA;
            opBQ       <= selB << selShift;
            opBShiftQ  <= selShift;
            opBIsZeroQ <= (selB == '0);
            opBSignQ   <= selOp[0] & selB[WIDTH-1];
            opCodeQ    <= selOp;
            ownerQ     <= gnt1;
            lastGntQ   <= gnt1;
            dropQ      <= 1'b0;
            stateQ     <= LOAD;
          end
        end
        // Launch stage: the divider samples InVld during this single cycle.
        LOAD: begin
          if (ownerFlush) dropQ <= 1'b1;
          stateQ <= BUSY;
        end
        // Divide stage: the divider cannot be aborted, so a flushed operation
        // still runs to completion and its result is discarded here.
        BUSY: begin
          if (ownerFlush) dropQ <= 1'b1;
          if (DivOutVld_SI) begin
            resQ   <= DivRes_DI;
            stateQ <= (dropQ | ownerFlush) ? IDLE : RESP;
          end
        end
        // Response stage: hold the result until the owner takes or flushes it.
        RESP: begin
          if (ownerResRdy | ownerFlush) stateQ <= IDLE;
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign DivOpA_DO       = opAQ;
  assign DivOpB_DO       = opBQ;
  assign DivOpBShift_DO  = opBShiftQ;
  assign DivOpBIsZero_SO = opBIsZeroQ;
  assign DivOpBSign_SO   = opBSignQ;
  assign DivOpCode_SO    = opCodeQ;
  assign DivInVld_SO     = (stateQ == LOAD);
  assign DivOutRdy_SO    = (stateQ == BUSY);
  assign Busy_SO         = ~idle;

  // A flush in RESP hides the result in the same cycle.
  assign Req0_ResVld_SO = (stateQ == RESP) & ~ownerQ & ~Req0_Flush_SI;
  assign Req1_ResVld_SO = (stateQ == RESP) &  ownerQ & ~Req1_Flush_SI;
  assign Req0_Res_DO    = resQ;
  assign Req1_Res_DO    = resQ;

endmodule

// File: tb/tb_cv32e40px_div_arbiter.sv
`timescale 1ns/1ps

module tb_cv32e40px_div_arbiter;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    int          flushDly;   // <0: no flush, else cycles after LOAD begins
    bit          useExp;
    logic [31:0] exp;
  } stim_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    int          s;
  } divExp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] opA [2];
  logic [31:0] opB [2];
  logic [1:0]  opc [2];
  logic        vld [2];
  logic        flush [2];
  logic        resRdy [2];

  logic        rdy0, rdy1, resVld0, resVld1;
  logic [31:0] res0, res1;
  logic [31:0] divOpA, divOpB, divRes;
  logic [5:0]  divShift;
  logic        divZero, divSign, divInVld, divOutRdy, divOutVld, busy;
  logic [1:0]  divCode;

  int nAssert = 0;
  int nFail   = 0;
  int cyc     = 0;
  bit rrRand  = 1'b0;
  bit seen [2];
  int lastAcc [2];

  stim_t   stimQ0[$];
  stim_t   stimQ1[$];
  exp_t    resQ0[$];
  exp_t    resQ1[$];
  divExp_t divQ[$];
  int      gntLog[$];

  cv32e40px_div_arbiter #(.WIDTH(32), .LOG_WIDTH(6)) dut (
    .Clk_CI(clk), .Rst_RBI(rstN),
    .Req0_OpA_DI(opA[0]), .Req0_OpB_DI(opB[0]), .Req0_OpCode_SI(opc[0]),
    .Req0_Vld_SI(vld[0]), .Req0_Rdy_SO(rdy0), .Req0_Flush_SI(flush[0]),
    .Req0_ResVld_SO(resVld0), .Req0_ResRdy_SI(resRdy[0]), .Req0_Res_DO(res0),
    .Req1_OpA_DI(opA[1]), .Req1_OpB_DI(opB[1]), .Req1_OpCode_SI(opc[1]),
    .Req1_Vld_SI(vld[1]), .Req1_Rdy_SO(rdy1), .Req1_Flush_SI(flush[1]),
    .Req1_ResVld_SO(resVld1), .Req1_ResRdy_SI(resRdy[1]), .Req1_Res_DO(res1),
    .DivOpA_DO(divOpA), .DivOpB_DO(divOpB), .DivOpBShift_DO(divShift),
    .DivOpBIsZero_SO(divZero), .DivOpBSign_SO(divSign), .DivOpCode_SO(divCode),
    .DivInVld_SO(divInVld), .DivOutRdy_SO(divOutRdy), .DivOutVld_SI(divOutVld),
    .DivRes_DI(divRes), .Busy_SO(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension semantics, straight from the ISA rules.
  function automatic logic [31:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    logic signed [31:0] sa, sb, r;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'd0: return a / b;
      2'd1: begin r = sa / sb; return r; end
      2'd2: return a % b;
      default: begin r = sa % sb; return r; end
    endcase
  endfunction

  function automatic int refShift(input logic [31:0] b, input logic [1:0] op);
    int   n;
    logic lead;
    n    = 0;
    lead = op[0] ? b[31] : 1'b0;
    while (n < 32 && b[31-n] == lead) n++;
    return op[0] ? n - 1 : n;
  endfunction

  // Behavioural divider: undoes the normalisation shift to get the divisor back.
  function automatic logic [31:0] divModel(input logic [31:0] a, input logic [31:0] bsh,
                                           input logic [5:0] sh, input logic zero,
                                           input logic [1:0] op);
    logic [31:0] b;
    if (op[0]) b = 32'($signed(bsh) >>> sh);
    else       b = bsh >> sh;
    if (zero) b = 32'h0;
    return refResult(a, b, op);
  endfunction

  int          dSt;
  int          dCnt;
  logic [31:0] dRes;
  assign divOutVld = (dSt == 2);
  assign divRes    = dRes;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dSt  <= 0;
      dCnt <= 0;
      dRes <= 32'h0;
    end else begin
      case (dSt)
        0: if (divInVld) begin
          if (divQ.size() == 0) begin
            chk("div_unexpected_start", 32'(divInVld), 32'h0);
          end else begin
            divExp_t e;
            e = divQ.pop_front();
            chk("div_opa", divOpA, e.a);
            chk("div_opb", divOpB, e.b << e.s);
            chk("div_shift", 32'(divShift), e.s);
            chk("div_zero", 32'(divZero), 32'(e.b == 32'h0));
            chk("div_sign", 32'(divSign), 32'(e.op[0] & e.b[31]));
            chk("div_opcode", 32'(divCode), 32'(e.op));
          end
          dCnt <= int'(divShift);
          dRes <= divModel(divOpA, divOpB, divShift, divZero, divCode);
          dSt  <= 1;
        end
        1: if (dCnt == 0) dSt <= 2; else dCnt <= dCnt - 1;
        default: if (divOutRdy) dSt <= 0;
      endcase
    end
  end

  initial begin
    resRdy[0] = 1'b1;
    resRdy[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      resRdy[0] = rrRand ? 1'($urandom_range(0, 1)) : 1'b1;
      resRdy[1] = rrRand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic monitorPort(input int p, input logic v, input logic [31:0] r);
    exp_t e;
    int   n;
    if (!v) return;
    n = (p == 0) ? resQ0.size() : resQ1.size();
    if (n == 0) begin
      nAssert++;
      nFail++;
      $display("FAIL unexpected_resvld port %0d: got res %h, expected no result (cycle %0d)", p, r, cyc);
      return;
    end
    e = (p == 0) ? resQ0[0] : resQ1[0];
    if (!seen[p]) chk($sformatf("latency_p%0d", p), cyc - e.acc, e.lat);
    chk($sformatf("result_p%0d", p), r, e.res);
    seen[p] = 1'b1;
    if (resRdy[p]) begin
      if (p == 0) void'(resQ0.pop_front());
      else        void'(resQ1.pop_front());
      seen[p] = 1'b0;
    end
  endtask

  initial begin
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        seen[0] = 1'b0;
        seen[1] = 1'b0;
      end else begin
        monitorPort(0, resVld0, res0);
        monitorPort(1, resVld1, res1);
        if (resVld0 | resVld1) chk("resvld_exclusive", 32'(resVld0 & resVld1), 32'h0);
        if (rdy0 | rdy1) begin
          chk("rdy_exclusive", 32'(rdy0 & rdy1), 32'h0);
          chk("rdy0_eligible", 32'(rdy0 & ~(vld[0] & ~flush[0])), 32'h0);
          chk("rdy1_eligible", 32'(rdy1 & ~(vld[1] & ~flush[1])), 32'h0);
        end
      end
    end
  end

  task automatic addStim(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input int fd, input bit ue,
                         input logic [31:0] ex);
    stim_t s;
    s.a = a; s.b = b; s.op = op; s.flushDly = fd; s.useExp = ue; s.exp = ex;
    if (p == 0) stimQ0.push_back(s);
    else        stimQ1.push_back(s);
  endtask

  task automatic runPort(input int p);
    stim_t   s;
    exp_t    e;
    divExp_t d;
    int      w;
    bit      got;
    @(posedge clk);
    #1;
    while (((p == 0) ? stimQ0.size() : stimQ1.size()) > 0) begin
      s = (p == 0) ? stimQ0.pop_front() : stimQ1.pop_front();
      opA[p] = s.a;
      opB[p] = s.b;
      opc[p] = s.op;
      vld[p] = 1'b1;
      w   = 0;
      got = 1'b0;
      while (!got && w < 400) begin
        @(negedge clk);
        if ((p == 0) ? rdy0 : rdy1) got = 1'b1;
        else w++;
      end
      if (!got) begin
        chk($sformatf("rdy_timeout_p%0d", p), 32'(got), 32'h1);
        vld[p] = 1'b0;
        return;
      end
      d.a = s.a; d.b = s.b; d.op = s.op; d.s = refShift(s.b, s.op);
      divQ.push_back(d);
      if (s.flushDly < 0) begin
        e.res = s.useExp ? s.exp : refResult(s.a, s.b, s.op);
        e.lat = d.s + 4;
        e.acc = cyc;
        if (p == 0) resQ0.push_back(e);
        else        resQ1.push_back(e);
      end
      gntLog.push_back(p);
      lastAcc[p] = cyc;
      @(posedge clk);
      #1;
      vld[p] = 1'b0;
      if (s.flushDly >= 0) begin
        repeat (s.flushDly) begin
          @(posedge clk);
          #1;
        end
        flush[p] = 1'b1;
        @(posedge clk);
        #1;
        flush[p] = 1'b0;
      end
    end
  endtask

  task automatic waitDrain(input string tag);
    int w;
    w = 0;
    while ((resQ0.size() != 0 || resQ1.size() != 0 || busy) && w < 3000) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk({tag, "_drain_timeout"}, 32'(w < 3000), 32'h1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
    chk({tag, "_divq_empty"}, divQ.size(), 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_rdy"}, 32'({rdy1, rdy0}), 32'h0);
    chk({tag, "_resvld"}, 32'({resVld1, resVld0}), 32'h0);
    chk({tag, "_res0"}, res0, 32'h0);
    chk({tag, "_res1"}, res1, 32'h0);
    chk({tag, "_divopa"}, divOpA, 32'h0);
    chk({tag, "_divopb"}, divOpB, 32'h0);
    chk({tag, "_divctl"}, 32'({divShift, divZero, divSign, divCode, divInVld, divOutRdy}), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  function automatic logic [31:0] randB();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 15));
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rstN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      opA[i] = 32'h0; opB[i] = 32'h0; opc[i] = 2'd0;
      vld[i] = 1'b0; flush[i] = 1'b0; lastAcc[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rstN = 1'b1;

    // Both ports request back to back with ResRdy high: grants alternate from port 0.
    for (int i = 0; i < 4; i++) begin
      addStim(0, $urandom, 32'($urandom_range(1, 1000)), 2'd0, -1, 1'b0, 32'h0);
      addStim(1, $urandom, 32'($urandom_range(1, 1000)), 2'd2, -1, 1'b0, 32'h0);
    end
    gntLog.delete();
    fork
      runPort(0);
      runPort(1);
    join
    waitDrain("alt");
    chk("alt_count", gntLog.size(), 32'd8);
    for (int i = 0; i < gntLog.size() && i < 8; i++)
      chk($sformatf("alt_grant_%0d", i), gntLog[i], i % 2);

    // Directed values.
    addStim(0, 32'd100, 32'd7, 2'd0, -1, 1'b1, 32'd14);
    addStim(0, 32'd100, 32'd7, 2'd2, -1, 1'b1, 32'd2);
    addStim(0, 32'h1234, 32'h0, 2'd0, -1, 1'b1, 32'hFFFF_FFFF);
    addStim(0, 32'h1234, 32'h0, 2'd2, -1, 1'b1, 32'h1234);
    addStim(0, 32'h1234, 32'h0, 2'd1, -1, 1'b1, 32'hFFFF_FFFF);
    addStim(1, 32'hFFFF_FFF9, 32'd2, 2'd1, -1, 1'b1, 32'hFFFF_FFFD);
    addStim(1, 32'hFFFF_FFF9, 32'd2, 2'd3, -1, 1'b1, 32'hFFFF_FFFF);
    addStim(1, 32'h8000_0000, 32'hFFFF_FFFF, 2'd1, -1, 1'b1, 32'h8000_0000);
    addStim(1, 32'h8000_0000, 32'hFFFF_FFFF, 2'd3, -1, 1'b1, 32'h0);
    fork
      runPort(0);
      runPort(1);
    join
    waitDrain("directed");

    // Flush port 0 in BUSY while port 1 waits; port 1 is granted in the IDLE
    // cycle right after the divider's FINISH (S=29 -> 33 cycles after port 0's Rdy).
    addStim(0, 32'd100, 32'd7, 2'd0, 10, 1'b0, 32'h0);
    addStim(1, 32'd50, 32'd5, 2'd0, -1, 1'b1, 32'd10);
    fork
      runPort(0);
      begin
        repeat (3) @(posedge clk);
        runPort(1);
      end
    join
    waitDrain("flush");
    chk("flush_grant_gap", lastAcc[1] - lastAcc[0], 32'd33);

    // Reset in the middle of BUSY, then a fresh operation.
    addStim(0, 32'h1000, 32'd3, 2'd0, -1, 1'b0, 32'h0);
    runPort(0);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_reset", 32'({busy, divOutRdy}), 32'h3);
    #1;
    rstN = 1'b0;
    #1;
    checkAllZero("midreset");
    resQ0.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    addStim(0, 32'd9, 32'd3, 2'd0, -1, 1'b1, 32'd3);
    runPort(0);
    waitDrain("postreset");

    // Random traffic on both ports with random ResRdy and occasional flushes.
    rrRand = 1'b1;
    for (int i = 0; i < 50; i++) begin
      logic [31:0] a, b;
      logic [1:0]  op;
      int          fd;
      a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b  = randB();
      op = 2'($urandom_range(0, 3));
      fd = ($urandom_range(0, 4) == 0) ? $urandom_range(0, refShift(b, op) + 3) : -1;
      addStim(i % 2, a, b, op, fd, 1'b0, 32'h0);
    end
    fork
      runPort(0);
      runPort(1);
    join
    waitDrain("random");
    rrRand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
